// File: rtl/pep_batch_builder_if.sv
// Handshake and status bundle between the PBS command source, the batch
// builder and its downstream consumers.
interface pep_batch_builder_if #(
    parameter int unsigned BATCH_PBS_NB = 18,
    parameter int unsigned TOTAL_PBS_NB = 27,
    parameter int unsigned CMD_W        = 32,
    parameter int unsigned TIMEOUT_W    = 16
);
    localparam int unsigned SLOT_W = $clog2(TOTAL_PBS_NB);
    localparam int unsigned NB_W   = $clog2(BATCH_PBS_NB + 1);
    localparam int unsigned FCNT_W = $clog2(TOTAL_PBS_NB + 1);

    logic                 cmd_vld;
    logic                 cmd_rdy;
    logic [CMD_W-1:0]     cmd_data;
    logic                 pbs_vld;
    logic                 pbs_rdy;
    logic [CMD_W-1:0]     pbs_data;
    logic [SLOT_W-1:0]    pbs_slot;
    logic                 batch_vld;
    logic                 batch_rdy;
    logic [NB_W-1:0]      batch_pbs_nb;
    logic                 free_vld;
    logic [SLOT_W-1:0]    free_slot;
    logic                 flush;
    logic [TIMEOUT_W-1:0] timeout_cfg;
    logic [FCNT_W-1:0]    free_cnt;
    logic                 err_free;

    modport master (
        output cmd_vld, cmd_data, pbs_rdy, batch_rdy, free_vld, free_slot, flush, timeout_cfg,
        input  cmd_rdy, pbs_vld, pbs_data, pbs_slot, batch_vld, batch_pbs_nb, free_cnt, err_free
    );

    modport slave (
        input  cmd_vld, cmd_data, pbs_rdy, batch_rdy, free_vld, free_slot, flush, timeout_cfg,
        output cmd_rdy, pbs_vld, pbs_data, pbs_slot, batch_vld, batch_pbs_nb, free_cnt, err_free
    );
endinterface

// File: rtl/pep_batch_builder.sv
// Groups incoming PBS commands into batches, owns the PBS slot pool and
// interleaves slot allocation across the GRAM banks.
module pep_batch_builder #(
    parameter int unsigned BATCH_PBS_NB = 18,
    parameter int unsigned TOTAL_PBS_NB = 27,
    parameter int unsigned GRAM_NB      = 3,
    parameter int unsigned CMD_W        = 32,
    parameter int unsigned TIMEOUT_W    = 16
) (
    input logic                clk,
    input logic                s_rst_n,
    pep_batch_builder_if.slave bus
);
    localparam int unsigned SLOT_W = $clog2(TOTAL_PBS_NB);
    localparam int unsigned NB_W   = $clog2(BATCH_PBS_NB + 1);
    localparam int unsigned FCNT_W = $clog2(TOTAL_PBS_NB + 1);

    typedef enum logic [1:0] {StIdle, StFill, StClose} state_e;

    state_e                state_q, state_d;
    logic                  init_pre_q, init_pre_d;
    logic                  init_done_q, init_done_d;
    logic [NB_W-1:0]       count_q, count_d;
    logic [TIMEOUT_W-1:0]  idle_q, idle_d;
    logic [TOTAL_PBS_NB-1:0] free_q, free_d;
    logic [FCNT_W-1:0]     free_cnt_q, free_cnt_d;
    logic                  pbs_vld_q, pbs_vld_d;
    logic [CMD_W-1:0]      pbs_data_q, pbs_data_d;
    logic [SLOT_W-1:0]     pbs_slot_q, pbs_slot_d;
    logic                  err_free_q, err_free_d;

    logic              cmd_rdy, accept, batch_vld, batch_hs;
    logic              rel_range, rel_hit, rel_ok;
    logic              bank_found, timeout_hit, close_now;
    logic [SLOT_W-1:0] bank_slot, any_slot, alloc_slot;
    int unsigned       pref_bank;

    // Lowest free slot in the preferred bank, else lowest free slot overall.
    always_comb begin
        pref_bank  = 32'(count_q) % GRAM_NB;
        bank_found = 1'b0;
        bank_slot  = '0;
        any_slot   = '0;
        for (int s = int'(TOTAL_PBS_NB) - 1; s >= 0; s--) begin
            if (free_q[s]) begin
                any_slot = SLOT_W'(s);
                if ((unsigned'(s) % GRAM_NB) == pref_bank) begin
                    bank_found = 1'b1;
                    bank_slot  = SLOT_W'(s);
                end
            end
        end
        alloc_slot = bank_found ? bank_slot : any_slot;
    end

    always_comb begin
        rel_range = 32'(bus.free_slot) < TOTAL_PBS_NB;
        rel_hit   = 1'b0;
        for (int s = 0; s < int'(TOTAL_PBS_NB); s++) begin
            if (bus.free_slot == SLOT_W'(s)) rel_hit = free_q[s];
        end
        rel_ok = bus.free_vld & rel_range & ~rel_hit;
    end

    always_comb begin
        cmd_rdy = init_done_q & (state_q != StClose) & (free_cnt_q != '0) &
                  (~pbs_vld_q | bus.pbs_rdy);
        accept    = bus.cmd_vld & cmd_rdy;
        // Batch close waits for its last entry to leave the pbs register.
        batch_vld = (state_q == StClose) & ~pbs_vld_q;
        batch_hs  = batch_vld & bus.batch_rdy;
    end

    always_comb begin
        init_pre_d  = 1'b1;
        init_done_d = init_pre_q;

        // Allocation works on the pre-release bitmap; the two never target one slot.
        free_d = free_q;
        for (int s = 0; s < int'(TOTAL_PBS_NB); s++) begin
            if (accept && alloc_slot == SLOT_W'(s)) free_d[s] = 1'b0;
            if (rel_ok && bus.free_slot == SLOT_W'(s)) free_d[s] = 1'b1;
        end
        free_cnt_d = free_cnt_q - FCNT_W'(accept) + FCNT_W'(rel_ok);
        err_free_d = bus.free_vld & ~rel_ok;

        pbs_vld_d  = pbs_vld_q;
        pbs_data_d = pbs_data_q;
        pbs_slot_d = pbs_slot_q;
        if (accept) begin
            pbs_vld_d  = 1'b1;
            pbs_data_d = bus.cmd_data;
            pbs_slot_d = alloc_slot;
        end else if (bus.pbs_rdy) begin
            pbs_vld_d = 1'b0;
        end

        timeout_hit = (bus.timeout_cfg != '0) && (state_q == StFill) && !accept &&
                      (idle_q == bus.timeout_cfg - TIMEOUT_W'(1));
        close_now = 1'b0;
        count_d   = count_q;
        idle_d    = idle_q;
        state_d   = state_q;
        if (state_q == StClose) begin
            if (batch_hs) begin
                count_d = '0;
                idle_d  = '0;
                state_d = StIdle;
            end
        end else begin
            if (accept) begin
                count_d = count_q + NB_W'(1);
                idle_d  = '0;
            end else if (state_q == StFill && idle_q != '1) begin
                idle_d = idle_q + TIMEOUT_W'(1);
            end
            close_now = (count_d == NB_W'(BATCH_PBS_NB)) ||
                        ((count_d != '0) && ((free_cnt_d == '0) || bus.flush)) ||
                        timeout_hit;
            if (close_now) begin
                state_d = StClose;
            end else if (count_d != '0) begin
                state_d = StFill;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q     <= StIdle;
            init_pre_q  <= 1'b0;
            init_done_q <= 1'b0;
            count_q     <= '0;
            idle_q      <= '0;
            free_q      <= '1;
            free_cnt_q  <= FCNT_W'(TOTAL_PBS_NB);
            pbs_vld_q   <= 1'b0;
            pbs_data_q  <= '0;
            pbs_slot_q  <= '0;
            err_free_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_pre_q  <= init_pre_d;
            init_done_q <= init_done_d;
            count_q     <= count_d;
            idle_q      <= idle_d;
            free_q      <= free_d;
            free_cnt_q  <= free_cnt_d;
            pbs_vld_q   <= pbs_vld_d;
            pbs_data_q  <= pbs_data_d;
            pbs_slot_q  <= pbs_slot_d;
            err_free_q  <= err_free_d;
        end
    end

    assign bus.cmd_rdy      = cmd_rdy;
    assign bus.pbs_vld      = pbs_vld_q;
    assign bus.pbs_data     = pbs_data_q;
    assign bus.pbs_slot     = pbs_slot_q;
    assign bus.batch_vld    = batch_vld;
    assign bus.batch_pbs_nb = count_q;
    assign bus.free_cnt     = free_cnt_q;
    assign bus.err_free     = err_free_q;
endmodule
